aes_iter_ctrl: RTL and testbench

Iterative AES-128 encryption sequencer. It time-multiplexes one external single-round datapath (sub_byte -> shift_row -> mix_col -> key_gen round-key expansion/AddRoundKey) over the 10 AES rounds, instead of unrolling them as a chain. It does the following:
- holds the state and round-key registers;
- generates the round constant;
- flags the final round, where mix_col is bypassed;
- provides valid/ready handshakes on the plaintext and ciphertext sides.

---
 rtl/aes_iter_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_aes_iter_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_iter_ctrl.sv
// -----------------------------------------------------------------------------
// aes_iter_ctrl
//
// Iterative AES-128 encryption sequencer. One external single-round datapath
// (SubBytes -> ShiftRows -> MixColumns -> AddRoundKey, plus round-key
// expansion) is reused for all NR rounds. This block holds the state and
// round-key registers, generates the round constant, flags the final round
// (where the datapath bypasses MixColumns), and provides valid/ready
// handshakes on the plaintext and ciphertext sides.
//
// Ports:
//   clk           in   1   clock, rising edge
//   rst_n         in   1   synchronous active-low reset
//   in_valid      in   1   plaintext/key request
//   in_ready      out  1   controller idle and able to accept a block
//   data_in       in   W   plaintext
//   key_in        in   W   cipher key
//   out_valid     out  1   ciphertext available (held until accepted)
//   out_ready     in   1   consumer accepts ciphertext
//   data_out      out  W   ciphertext (kept after retirement)
//   busy          out  1   high while running or holding a result
//   rd_state      out  W   state presented to the round datapath
//   rd_key        out  W   previous round key presented to key expansion
//   rd_rcon       out  32  round constant {rcon_byte, 24'h0}
//   rd_last       out  1   final round: datapath must bypass MixColumns
//   rd_state_nxt  in   W   datapath round output after AddRoundKey
//   rd_key_nxt    in   W   datapath expanded round key
//   round         out  4   current round number, 0 when not running
// -----------------------------------------------------------------------------
module aes_iter_ctrl #(
    parameter int NR = 10,
    parameter int W  = 128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] data_in,
    input  logic [W-1:0] key_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] data_out,
    output logic         busy,
    output logic [W-1:0] rd_state,
    output logic [W-1:0] rd_key,
    output logic [31:0]  rd_rcon,
    output logic         rd_last,
    input  logic [W-1:0] rd_state_nxt,
    input  logic [W-1:0] rd_key_nxt,
    output logic [3:0]   round
);

    localparam logic [3:0] LP_NR = 4'(NR);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } fsm_t;

    // GF(2^8) multiply-by-x; steps the round constant 01,02,..,80,1b,36.
    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

    fsm_t         r_fsm;
    fsm_t         w_fsm_nxt;
    logic [W-1:0] r_state;
    logic [W-1:0] r_key;
    logic [W-1:0] r_data_out;
    logic [3:0]   r_round;
    logic [7:0]   r_rcon;
    logic         r_out_valid;

    logic         w_in_ready;
    logic         w_busy;
    logic         w_run;
    logic         w_last;
    logic         w_accept;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fsm <= S_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    // Next-state and status decode.
    always_comb begin
        w_fsm_nxt  = r_fsm;
        w_in_ready = 1'b0;
        w_busy     = 1'b0;
        w_run      = 1'b0;
        case (r_fsm)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_fsm_nxt = S_RUN;
                end else begin
                    w_fsm_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                w_run  = 1'b1;
                if (r_round == LP_NR) begin
                    w_fsm_nxt = S_DONE;
                end else begin
                    w_fsm_nxt = S_RUN;
                end
            end
            S_DONE: begin
                w_busy = 1'b1;
                // Retire on handshake; the result is held otherwise.
                if (out_ready) begin
                    w_fsm_nxt = S_IDLE;
                end else begin
                    w_fsm_nxt = S_DONE;
                end
            end
            default: begin
                w_fsm_nxt = S_IDLE;
            end
        endcase
    end

    assign w_accept = w_in_ready && in_valid;
    assign w_last   = w_run && (r_round == LP_NR);

    // State, key, round counter, rcon and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= '0;
            r_key       <= '0;
            r_data_out  <= '0;
            r_round     <= 4'd0;
            r_rcon      <= 8'h01;
            r_out_valid <= 1'b0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (w_accept) begin
                        // Initial AddRoundKey is folded into the load.
                        r_state <= data_in ^ key_in;
                        r_key   <= key_in;
                        r_round <= 4'd1;
                        r_rcon  <= 8'h01;
                    end
                end
                S_RUN: begin
                    r_state <= rd_state_nxt;
                    r_key   <= rd_key_nxt;
                    r_rcon  <= xtime(r_rcon);
                    if (w_last) begin
                        r_data_out  <= rd_state_nxt;
                        r_out_valid <= 1'b1;
                        r_round     <= 4'd0;
                    end else begin
                        r_round <= r_round + 4'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign busy      = w_busy;
    assign out_valid = r_out_valid;
    assign data_out  = r_data_out;
    assign round     = r_round;

    // Datapath operands are zeroed outside RUN; rcon is always visible.
    assign rd_state = w_run ? r_state : '0;
    assign rd_key   = w_run ? r_key   : '0;
    assign rd_last  = w_last;
    assign rd_rcon  = {r_rcon, 24'h000000};

endmodule

// File: tb/tb_aes_iter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_iter_ctrl
//
// Bench for aes_iter_ctrl with a behavioural AES round datapath attached.
// Expected ciphertexts are pushed into a queue when a block is issued; a
// negedge monitor pops and compares on every output handshake, and also
// checks rd_rcon / rd_last against the round number each cycle.
// -----------------------------------------------------------------------------
module tb_aes_iter_ctrl;

    localparam int NR = 10;
    localparam int W  = 128;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] data_in;
    logic [W-1:0] key_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] data_out;
    logic         busy;
    logic [W-1:0] rd_state;
    logic [W-1:0] rd_key;
    logic [31:0]  rd_rcon;
    logic         rd_last;
    logic [W-1:0] rd_state_nxt;
    logic [W-1:0] rd_key_nxt;
    logic [3:0]   round;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    bit mon_en  = 1'b0;
    logic [W-1:0] exp_q [$];
    logic [7:0]   rcon_exp [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    aes_iter_ctrl #(.NR(NR), .W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .key_in(key_in),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .busy(busy),
        .rd_state(rd_state), .rd_key(rd_key), .rd_rcon(rd_rcon),
        .rd_last(rd_last),
        .rd_state_nxt(rd_state_nxt), .rd_key_nxt(rd_key_nxt),
        .round(round)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference AES round datapath ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // S-box computed as GF inverse (a^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r, base, e;
        r = 8'h01; base = a; e = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gmul(r, base);
            base = gmul(base, base);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] key_exp(input logic [127:0] k, input logic [31:0] rc);
        logic [31:0] w3, rot, temp, n0, n1, n2, n3;
        w3   = k[31:0];
        rot  = {w3[23:0], w3[31:24]};
        temp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ rc;
        n0 = k[127:96] ^ temp;
        n1 = k[95:64]  ^ n0;
        n2 = k[63:32]  ^ n1;
        n3 = k[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [7:0] b [16];
        logic [7:0] t [16];
        logic [7:0] m [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                t[r + 4*c] = b[r + 4*((c + r) % 4)];
        for (int c = 0; c < 4; c++) begin
            if (last) begin
                for (int r = 0; r < 4; r++) m[r + 4*c] = t[r + 4*c];
            end else begin
                m[4*c]   = gmul(8'h02, t[4*c]) ^ gmul(8'h03, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
                m[4*c+1] = t[4*c] ^ gmul(8'h02, t[4*c+1]) ^ gmul(8'h03, t[4*c+2]) ^ t[4*c+3];
                m[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(8'h02, t[4*c+2]) ^ gmul(8'h03, t[4*c+3]);
                m[4*c+3] = gmul(8'h03, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(8'h02, t[4*c+3]);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = m[i];
        return o ^ rk;
    endfunction

    assign rd_key_nxt   = key_exp(rd_key, rd_rcon);
    assign rd_state_nxt = aes_round(rd_state, rd_key_nxt, rd_last);

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a block, wait for acceptance; acc is the accept cycle.
    task automatic send(input logic [127:0] d, input logic [127:0] k, input logic [127:0] e,
                        input bit push, output int acc);
        int n;
        n = 0;
        in_valid = 1'b1; data_in = d; key_in = k;
        if (push) exp_q.push_back(e);
        while (!in_ready && n < 50) begin tick(); n++; end
        if (n >= 50) chk("accept_timeout", 128'(n), 128'd0);
        acc = cyc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int acc, output int lat);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin tick(); n++; end
        lat = cyc - acc;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            chk("rd_last", 128'(rd_last), 128'(round == 4'd10));
            if (round != 4'd0 && round <= 4'd10)
                chk("rd_rcon", 128'(rd_rcon), 128'({rcon_exp[round - 4'd1], 24'h000000}));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    n_bad++;
                    $display("FAIL unexpected_out: got %h want none", data_out);
                end else begin
                    chk("data_out", data_out, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int a, b, lat, n;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        data_in = '0; key_in = '0;
        tick(); tick();
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Reset state
        chk("rst_in_ready",  128'(in_ready),  128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_busy",      128'(busy),      128'd0);
        chk("rst_round",     128'(round),     128'd0);
        chk("rst_data_out",  data_out,        128'd0);
        chk("rst_rcon",      128'(rd_rcon),   128'h01000000);

        // 1: FIPS-197 App. B, exact latency and round sequence
        out_ready = 1'b1;
        send(P1, K1, C1, 1'b1, a);
        for (int i = 1; i <= 10; i++) begin
            chk("t1_round", 128'(round), 128'(i));
            chk("t1_in_ready_run", 128'(in_ready), 128'd0);
            chk("t1_out_valid_early", 128'(out_valid), 128'd0);
            tick();
        end
        chk("t1_latency_ov", 128'(out_valid), 128'd1);
        chk("t1_in_ready_done", 128'(in_ready), 128'd0);
        chk("t1_busy_done", 128'(busy), 128'd1);
        tick();
        chk("t1_ov_retired", 128'(out_valid), 128'd0);
        chk("t1_in_ready_back", 128'(in_ready), 128'd1);
        chk("t1_data_out_kept", data_out, C1);

        // 2: FIPS-197 App. C.1
        send(P2, K2, C2, 1'b1, a);
        wait_out(a, lat);
        chk("t2_latency", 128'(lat), 128'd11);
        tick();
        chk("t2_in_ready_back", 128'(in_ready), 128'd1);

        // 4: backpressure, with an ignored second request
        out_ready = 1'b0;
        send(P1, K1, C1, 1'b1, a);
        wait_out(a, lat);
        chk("t4_latency", 128'(lat), 128'd11);
        in_valid = 1'b1; data_in = P2; key_in = K2;
        for (int i = 0; i < 7; i++) begin
            chk("t4_ov_held", 128'(out_valid), 128'd1);
            chk("t4_data_stable", data_out, C1);
            chk("t4_in_ready", 128'(in_ready), 128'd0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("t4_ov_retired", 128'(out_valid), 128'd0);
        chk("t4_in_ready_back", 128'(in_ready), 128'd1);
        chk("t4_busy_idle", 128'(busy), 128'd0);

        // 5: reset at round 5, then a clean block
        send(P1, K1, 128'd0, 1'b0, a);
        n = 0;
        while (round != 4'd5 && n < 20) begin tick(); n++; end
        chk("t5_round5", 128'(round), 128'd5);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t5_in_ready", 128'(in_ready), 128'd1);
        chk("t5_out_valid", 128'(out_valid), 128'd0);
        chk("t5_round", 128'(round), 128'd0);
        chk("t5_data_out", data_out, 128'd0);
        chk("t5_busy", 128'(busy), 128'd0);
        send(P2, K2, C2, 1'b1, a);
        wait_out(a, lat);
        chk("t5_latency", 128'(lat), 128'd11);
        tick();

        // 6: back-to-back with in_valid held high
        in_valid = 1'b1; data_in = P1; key_in = K1;
        exp_q.push_back(C1);
        exp_q.push_back(C2);
        n = 0;
        while (!in_ready && n < 40) begin tick(); n++; end
        a = cyc;
        tick();
        data_in = P2; key_in = K2;
        n = 0;
        while (!in_ready && n < 40) begin tick(); n++; end
        b = cyc;
        chk("t6_gap", 128'(b - a), 128'd12);
        tick();
        in_valid = 1'b0;
        wait_out(b, lat);
        chk("t6_latency", 128'(lat), 128'd11);
        tick(); tick();

        chk("queue_empty", 128'(exp_q.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
